// File: rtl/simd_reg_bank.sv
// Lane-masked SIMD register bank: NRD one-cycle read ports, per-lane write mask,
// optional write-to-read forwarding and a sequential hardware clear.
module simd_reg_bank #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned DBW    = 16,
    parameter int unsigned NWORD  = 64,
    parameter int unsigned NRD    = 2,
    parameter bit          WFIRST = 1'b1,
    localparam int unsigned ABW   = $clog2(NWORD),
    localparam int unsigned VW    = LANES * DBW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NRD-1:0]       i_re,
    input  logic [NRD*ABW-1:0]   i_raddr,
    output logic [NRD-1:0]       o_rvalid,
    output logic [NRD*VW-1:0]    o_rdata,
    input  logic                 i_we,
    input  logic [ABW-1:0]       i_waddr,
    input  logic [LANES-1:0]     i_wmask,
    input  logic [VW-1:0]        i_wdata,
    input  logic                 i_clr,
    output logic                 o_busy,
    output logic                 o_drop
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]     state_q;
    logic [0:0]     state_d;
    logic [ABW-1:0] cnt_q;
    logic [ABW-1:0] cnt_d;
    logic           busy_c;
    logic           wr_acc;
    logic [NRD-1:0] rd_acc;

    logic [VW-1:0]  mem     [NWORD];
    logic [VW-1:0]  rd_word [NRD];

    // State and clear-counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; accesses are only accepted outside the clear sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_c  = (state_q == S_CLEAR);
        wr_acc  = i_we && !busy_c;
        rd_acc  = busy_c ? '0 : i_re;
        case (state_q)
            S_IDLE: begin
                if (i_clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + ABW'(1);
                if (cnt_q == ABW'(NWORD - 1)) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Storage is deliberately not reset; a reset cycle leaves it untouched
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (busy_c) begin
                mem[cnt_q] <= '0;
            end else if (wr_acc) begin
                for (int l = 0; l < LANES; l++) begin
                    if (i_wmask[l]) begin
                        mem[i_waddr][l*DBW +: DBW] <= i_wdata[l*DBW +: DBW];
                    end
                end
            end
        end
    end

    // Read mux with optional same-cycle merge of the masked write lanes
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_word[k] = mem[i_raddr[k*ABW +: ABW]];
            if (WFIRST && wr_acc && (i_raddr[k*ABW +: ABW] == i_waddr)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (i_wmask[l]) begin
                        rd_word[k][l*DBW +: DBW] = i_wdata[l*DBW +: DBW];
                    end
                end
            end
        end
    end

    // Registered outputs; read data holds until the next accepted read
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rvalid <= '0;
            o_rdata  <= '0;
            o_busy   <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            o_rvalid <= rd_acc;
            o_busy   <= (state_d == S_CLEAR);
            o_drop   <= busy_c && ((|i_re) || i_we);
            for (int k = 0; k < NRD; k++) begin
                if (rd_acc[k]) begin
                    o_rdata[k*VW +: VW] <= rd_word[k];
                end
            end
        end
    end

endmodule

// File: doc/simd_reg_bank.md
# simd_reg_bank

Parametrised lane-masked SIMD register bank for the ALU pipeline: the next-generation replacement for the single-read, full-vector-write two-port register store between the SIMD operand stage and the ALU. It provides NRD independent read ports with one-cycle latency, a per-lane write mask, same-cycle write-to-read forwarding, and a multi-cycle hardware clear sequencer. The operand stage issues reads and the ALU writeback issues writes.

## Interface
- LANES, 32: vector lanes (VSIZE).
- DBW, 16: bits per lane (TMP_DATA_BW).
- NWORD, 64: vector entries; must be a power of two, ≥2.
- NRD, 2: read ports.
- WFIRST, 1: 1 = a same-cycle same-address read returns the new data; 0 = it returns the old data.
- ABW, derived: $clog2(NWORD).

- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_re  in  NRD  read enable per port
- i_raddr  in  NRD×ABW  read address per port
- o_rvalid  out  NRD  read data valid per port; 1-cycle pulse
- o_rdata  out  NRD×LANES×DBW  read data per port
- i_we  in  1  write enable
- i_waddr  in  ABW  write address
- i_wmask  in  LANES  lane write mask; 1 = write that lane
- i_wdata  in  LANES×DBW  write data
- i_clr  in  1  pulse: start clearing all entries
- o_busy  out  1  clear sequence in progress
- o_drop  out  1  1-cycle pulse: a read or write was discarded during busy

## Operation
- Storage is an NWORD×LANES×DBW flop array. Its contents are not reset.
- Write: when i_we=1 and not busy, lane l of entry i_waddr takes i_wdata[l] if i_wmask[l]=1. Other lanes are unchanged. i_wmask=0 is a legal no-op.
- Read: when i_re[k]=1 and not busy, port k captures the entry at i_raddr[k]. Ports are fully independent; any ports may read the same address.
- Forwarding (WFIRST=1): if i_re[k] and i_we occur in the same cycle with i_raddr[k]==i_waddr, the returned lane l is i_wdata[l] where i_wmask[l]=1, and the stored value elsewhere.
- Forwarding (WFIRST=0): the read returns the pre-write contents.
- o_rdata[k] holds its last value until the next accepted read on port k.
- State machine, IDLE → CLEAR:
  - In IDLE, i_clr=1 enters CLEAR with counter=0.
  - In CLEAR, entry[counter] is set to all zeros each cycle and the counter increments.
  - At counter==NWORD-1, that entry is zeroed and the state returns to IDLE. CLEAR lasts exactly NWORD cycles.
  - o_busy=1 exactly while in CLEAR.
- In CLEAR, any i_re or i_we is discarded: no storage change, no o_rvalid, and o_drop=1 on the following cycle.
- i_clr in CLEAR is ignored; the sequence does not restart.
- An i_clr and i_we in the same IDLE cycle: the write is performed, then the clear starts the next cycle and overwrites it.
- Reads in that same cycle are performed normally.

## Timing
- Reset values:
  - o_rvalid=0, o_rdata=0, o_busy=0, o_drop=0.
  - State=IDLE, counter=0.
- Reset asserted mid-CLEAR aborts the sequence. Entries not yet zeroed keep their contents.
- Read latency is 1: a read accepted in cycle t gives o_rvalid[k]=1 and valid o_rdata[k] in cycle t+1.
- Write-to-read: a write in cycle t is visible to a read accepted in cycle t+1. With WFIRST=1 it is also visible to a read in cycle t.
- o_busy rises in the cycle after i_clr and falls NWORD cycles later.
- A read accepted in the first cycle after o_busy falls returns zeros for never-rewritten entries.
- There is no back-pressure and no ready signal. The consumer must take o_rdata in the o_rvalid cycle or rely on the hold behaviour.
- Address width is exactly ABW, so no out-of-range addresses exist.

## Test plan
- Masked write: write entry 5, all lanes 0x1111. Then write entry 5 with i_wmask=0x0000_000F and data 0xAAAA. Read entry 5 on port 0 → lanes 0–3 = 0xAAAA, lanes 4–31 = 0x1111, o_rvalid[0]=1 one cycle later.
- Forwarding: entry 7 = 0x2222 everywhere. In one cycle, write entry 7 with mask 0x1, data 0x5555, and read 7 on ports 0 and 1.
  - WFIRST=1 → both ports return lane0 = 0x5555, others 0x2222.
  - WFIRST=0 → all lanes 0x2222.
- Dual port: in the same cycle, read entry 3 on port 0 and entry 60 on port 1 → each returns its own contents. Holding both i_re low afterwards keeps o_rdata unchanged for 10 cycles.
- Clear: fill all 64 entries with 0xFFFF, pulse i_clr → o_busy high for exactly 64 cycles. A subsequent read of entries 0, 31 and 63 returns 0.
- Drop during clear: issue i_we to entry 2 and i_re on port 1 during busy → o_drop pulses once, o_rvalid stays 0. After the clear, entry 2 reads 0.
- Reset mid-clear: pulse i_rst at clear cycle 10 → o_busy=0 next cycle. Entries 0–9 read 0 and entries 10–63 keep their prior contents.
